// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Receives a program image as a byte stream and writes it into code memory,
// holding the core in reset until a complete image with a matching checksum
// has been stored.
//
// Stream format: LEN_HI, LEN_LO (16-bit word count N), then 4*N data bytes
// (big-endian words), then one checksum byte equal to the XOR of all data
// bytes. The length bytes are not part of the checksum.
//
// Parameters
//   DEPTH      maximum number of 32-bit words code memory accepts
//   BASE_ADDR  byte address of the first word written
//
// Ports
//   clk         sole clock, rising edge
//   rst         asynchronous, active-low reset
//   start       single-cycle request to begin a load (IDLE/DONE/ERROR only)
//   rx_valid    rx_data holds a valid byte
//   rx_data     incoming byte
//   rx_ready    loader accepts a byte this cycle
//   imem_we     code-memory write strobe, one cycle per word
//   imem_addr   code-memory byte address
//   imem_wdata  assembled instruction word
//   core_rst_n  active-low core reset, released only in DONE
//   done        load completed with checksum match
//   err         load aborted (oversize or checksum mismatch)
// -----------------------------------------------------------------------------
module program_loader #(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        imem_we,
    output logic [31:0] imem_addr,
    output logic [31:0] imem_wdata,
    output logic        core_rst_n,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE,
        LEN_HI,
        LEN_LO,
        DATA,
        WRITE,
        CSUM,
        DONE,
        ERROR
    } state_t;

    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    state_t      state_reg,    state_next;
    logic [15:0] len_reg,      len_next;
    logic [15:0] word_cnt_reg, word_cnt_next;
    logic [1:0]  byte_cnt_reg, byte_cnt_next;
    logic [7:0]  csum_reg,     csum_next;
    logic [31:0] addr_reg,     addr_next;
    logic [31:0] wdata_reg,    wdata_next;

    logic        accept;
    logic [15:0] len_full;

    // Full word count as it will be once the LEN_LO byte is taken.
    assign len_full = {len_reg[15:8], rx_data};
    assign accept   = rx_valid & rx_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg    <= IDLE;
            len_reg      <= 16'd0;
            word_cnt_reg <= 16'd0;
            byte_cnt_reg <= 2'd0;
            csum_reg     <= 8'd0;
            addr_reg     <= BASE_ADDR;
            wdata_reg    <= 32'd0;
        end else begin
            state_reg    <= state_next;
            len_reg      <= len_next;
            word_cnt_reg <= word_cnt_next;
            byte_cnt_reg <= byte_cnt_next;
            csum_reg     <= csum_next;
            addr_reg     <= addr_next;
            wdata_reg    <= wdata_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        len_next      = len_reg;
        word_cnt_next = word_cnt_reg;
        byte_cnt_next = byte_cnt_reg;
        csum_next     = csum_reg;
        addr_next     = addr_reg;
        wdata_next    = wdata_reg;

        rx_ready   = 1'b0;
        imem_we    = 1'b0;
        core_rst_n = 1'b0;
        done       = 1'b0;
        err        = 1'b0;

        case (state_reg)
            IDLE, DONE, ERROR: begin
                done       = (state_reg == DONE);
                err        = (state_reg == ERROR);
                core_rst_n = (state_reg == DONE);
                if (start) begin
                    state_next    = LEN_HI;
                    len_next      = 16'd0;
                    word_cnt_next = 16'd0;
                    byte_cnt_next = 2'd0;
                    csum_next     = 8'd0;
                    addr_next     = BASE_ADDR;
                end
            end
            LEN_HI: begin
                rx_ready = 1'b1;
                if (accept) begin
                    len_next   = {rx_data, 8'd0};
                    state_next = LEN_LO;
                end
            end
            LEN_LO: begin
                rx_ready = 1'b1;
                if (accept) begin
                    len_next = len_full;
                    if ({16'd0, len_full} > DEPTH_W) begin
                        state_next = ERROR;
                    end else if (len_full == 16'd0) begin
                        state_next = CSUM;
                    end else begin
                        state_next = DATA;
                    end
                end
            end
            DATA: begin
                rx_ready = 1'b1;
                if (accept) begin
                    // Shift in so the first byte ends up in bits [31:24].
                    wdata_next    = {wdata_reg[23:0], rx_data};
                    csum_next     = csum_reg ^ rx_data;
                    byte_cnt_next = byte_cnt_reg + 2'd1;
                    if (byte_cnt_reg == 2'd3) begin
                        state_next = WRITE;
                    end
                end
            end
            WRITE: begin
                // Address and data are registers, so they stay stable for
                // the whole strobe cycle and only advance afterwards.
                imem_we       = 1'b1;
                addr_next     = addr_reg + 32'd4;
                word_cnt_next = word_cnt_reg + 16'd1;
                if (word_cnt_reg + 16'd1 == len_reg) begin
                    state_next = CSUM;
                end else begin
                    state_next = DATA;
                end
            end
            CSUM: begin
                rx_ready = 1'b1;
                if (accept) begin
                    state_next = (rx_data == csum_reg) ? DONE : ERROR;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign imem_addr  = addr_reg;
    assign imem_wdata = wdata_reg;

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//
// Self-checking bench for program_loader. Each load is described as a byte
// stream; a reference model derives the expected memory writes and the
// expected outcome directly from the stream format, and the bench compares
// the captured imem writes and status outputs against it.
// -----------------------------------------------------------------------------
module tb_program_loader;

    localparam int          DEPTH     = 256;
    localparam logic [31:0] BASE_ADDR = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_ready;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst_n;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    logic [7:0]  stream[$];
    logic [63:0] exp_writes[$];
    logic [63:0] got_writes[$];
    bit          exp_done;
    int          exp_nbytes;

    program_loader #(
        .DEPTH    (DEPTH),
        .BASE_ADDR(BASE_ADDR)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .core_rst_n(core_rst_n),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Capture every write strobe; a strobe also means no byte may be taken.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            got_writes.push_back({imem_addr, imem_wdata});
            check("ready_low_in_write", {63'd0, rx_ready}, 64'd0);
        end
    end

    // Reference model: interpret the stream by its format rules.
    function automatic void model();
        int          n;
        logic [7:0]  cs;
        logic [31:0] word;
        exp_writes.delete();
        n = int'({stream[0], stream[1]});
        if (n > DEPTH) begin
            exp_done   = 1'b0;
            exp_nbytes = 2;
            return;
        end
        cs = 8'd0;
        for (int w = 0; w < n; w++) begin
            word = {stream[2+4*w], stream[3+4*w], stream[4+4*w], stream[5+4*w]};
            cs   = cs ^ stream[2+4*w] ^ stream[3+4*w] ^ stream[4+4*w] ^ stream[5+4*w];
            exp_writes.push_back({BASE_ADDR + 32'(4 * w), word});
        end
        exp_nbytes = 2 + 4 * n + 1;
        exp_done   = (stream[2+4*n] == cs);
    endfunction

    // Build a random stream of n words; the trailer is correct when good=1.
    task automatic make_stream(input int n, input bit good);
        logic [7:0] cs;
        logic [7:0] b;
        stream.delete();
        stream.push_back(8'(n >> 8));
        stream.push_back(8'(n));
        cs = 8'd0;
        for (int i = 0; i < 4 * n; i++) begin
            b  = 8'($urandom);
            cs = cs ^ b;
            stream.push_back(b);
        end
        if (!good) cs = cs ^ 8'($urandom_range(1, 255));
        stream.push_back(cs);
    endtask

    // Offer one byte until it is accepted; with rnd=1 valid drops randomly
    // and garbage appears on rx_data while valid is low.
    task automatic send_byte(input logic [7:0] b, input bit rnd, output bit ok);
        int guard;
        bit taken;
        guard = 0;
        taken = 1'b0;
        while (!taken && guard < 200) begin
            @(negedge clk);
            if (rnd && $urandom_range(0, 2) == 0) begin
                rx_valid = 1'b0;
                rx_data  = 8'($urandom);
            end else begin
                rx_valid = 1'b1;
                rx_data  = b;
            end
            #1;
            taken = rx_valid && rx_ready;
            @(posedge clk);
            guard++;
        end
        ok = taken;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_load(input string name, input bit rnd);
        bit ok;
        model();
        got_writes.delete();
        pulse_start();
        for (int i = 0; i < exp_nbytes; i++) begin
            send_byte(stream[i], rnd, ok);
            if (!ok) begin
                check({name, "_byte_timeout"}, 64'(i), 64'(exp_nbytes));
                break;
            end
        end
        @(negedge clk);
        rx_valid = 1'b0;
        #1;
        check({name, "_nwrites"}, 64'(got_writes.size()), 64'(exp_writes.size()));
        for (int i = 0; i < exp_writes.size() && i < got_writes.size(); i++)
            check($sformatf("%s_write%0d", name, i), got_writes[i], exp_writes[i]);
        check({name, "_done"},       {63'd0, done},       {63'd0, exp_done});
        check({name, "_err"},        {63'd0, err},        {63'd0, !exp_done});
        check({name, "_core_rst_n"}, {63'd0, core_rst_n}, {63'd0, exp_done});
        check({name, "_we_idle"},    {63'd0, imem_we},    64'd0);
        $display("load %s: words=%0d writes=%0d done=%0b err=%0b", name,
                 exp_writes.size(), got_writes.size(), done, err);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_rx_ready"},   {63'd0, rx_ready},   64'd0);
        check({name, "_imem_we"},    {63'd0, imem_we},    64'd0);
        check({name, "_imem_addr"},  {32'd0, imem_addr},  {32'd0, BASE_ADDR});
        check({name, "_imem_wdata"}, {32'd0, imem_wdata}, 64'd0);
        check({name, "_core_rst_n"}, {63'd0, core_rst_n}, 64'd0);
        check({name, "_done"},       {63'd0, done},       64'd0);
        check({name, "_err"},        {63'd0, err},        64'd0);
    endtask

    initial begin
        bit ok;

        // Reset state
        #12;
        check_reset_outputs("por");
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("no_load_without_start", {63'd0, rx_ready}, 64'd0);

        // Two-word image; the XOR of its data bytes is 0x31.
        stream = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF,
                   8'h00, 8'h00, 8'h00, 8'h13, 8'h31};
        run_load("two_word_good", 1'b0);
        if (got_writes.size() == 2) begin
            check("two_word_w0_literal", got_writes[0], 64'h00000000_DEADBEEF);
            check("two_word_w1_literal", got_writes[1], 64'h00000004_00000013);
        end else begin
            check("two_word_count_literal", 64'(got_writes.size()), 64'd2);
        end

        // Same image, wrong checksum
        stream[10] = 8'h3F;
        run_load("two_word_bad", 1'b0);

        // Oversize length aborts right after LEN_LO
        stream = '{8'h01, 8'h01};
        run_load("oversize", 1'b0);

        // Exactly DEPTH words is accepted
        make_stream(DEPTH, 1'b1);
        run_load("full_depth", 1'b0);

        // Zero-length images
        stream = '{8'h00, 8'h00, 8'h00};
        run_load("zero_good", 1'b0);
        stream = '{8'h00, 8'h00, 8'h01};
        run_load("zero_bad", 1'b0);

        // Three-word loads with random valid gaps
        for (int k = 0; k < 4; k++) begin
            make_stream(3, k != 2);
            run_load($sformatf("rand3_%0d", k), 1'b1);
        end

        // Random lengths, both stream styles
        for (int k = 0; k < 4; k++) begin
            make_stream($urandom_range(1, 6), $urandom_range(0, 3) != 0);
            run_load($sformatf("randlen_%0d", k), k[0]);
        end

        // Reset in the middle of a load
        make_stream(1, 1'b1);
        got_writes.delete();
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            send_byte(stream[i], 1'b0, ok);
            if (!ok) check("midrst_byte_timeout", 64'(i), 64'd4);
        end
        @(negedge clk);
        rx_valid = 1'b0;
        rst      = 1'b0;
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("midrst_hold");
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("midrst_no_restart", {63'd0, rx_ready}, 64'd0);
        check("midrst_no_writes", 64'(got_writes.size()), 64'd0);
        make_stream(1, 1'b1);
        run_load("after_rst", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
